uart_partner_rx: RTL and testbench

- Synthesizable UART receiver that acts as the communication partner on the SoC serial line. Its uart_rxd input connects to the system's uart_txd.
- Recovers 8N1 frames and presents each byte through a valid/ack holding register, with framing-error and overrun flags.
- Used in the system testbench and in loopback and bring-up harnesses next to the system instance.

---
 rtl/uart_partner_rx.sv | 152 +++++++++++++++
 tb/tb_uart_partner_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_partner_rx.sv
`default_nettype none
// uart_partner_rx: 8N1 UART receiver with a valid/ack holding register and sticky
// framing-error / overrun flags. Rev 1.0
module uart_partner_rx #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       rx_error,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int CPB  = clk_freq / uart_baud_rate;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] c_half_m1 = CW'(HALF - 1);
  localparam logic [CW-1:0] c_cpb_m1  = CW'(CPB - 1);

  generate
    if (CPB < 16) begin : g_cpb_check
      $error("uart_partner_rx: clk_freq/uart_baud_rate must be at least 16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_avail;
  logic          r_rx_error;
  logic          r_rx_overrun;
  logic          w_data_smp;
  logic          w_load;
  logic          w_frame_err;

  // The line is asynchronous; reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_smp   = 1'b0;
    w_load       = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) w_state_next = S_START;
      end
      S_START: begin
        if (r_cnt == c_half_m1) w_state_next = r_sync2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (r_cnt == c_cpb_m1) begin
          w_data_smp = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == c_cpb_m1) begin
          if (r_sync2) begin
            w_load       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_sync2) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state <= w_state_next;
      // Bit timer restarts on every state change and on every data-bit sample.
      if ((w_state_next != r_state) || w_data_smp || (r_state == S_IDLE) || (r_state == S_BREAK))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_START)
        r_bit_idx <= 3'd0;
      else if (w_data_smp)
        r_bit_idx <= r_bit_idx + 3'd1;
      if (w_data_smp)
        r_shift <= {r_sync2, r_shift[7:1]};
    end
  end

  // Sets are ordered after the ack clear so a same-cycle load or error wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_data    <= 8'h00;
      r_rx_avail   <= 1'b0;
      r_rx_error   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (rx_ack) begin
        r_rx_avail   <= 1'b0;
        r_rx_error   <= 1'b0;
        r_rx_overrun <= 1'b0;
      end
      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_avail <= 1'b1;
        if (r_rx_avail && !rx_ack) r_rx_overrun <= 1'b1;
      end
      if (w_frame_err) r_rx_error <= 1'b1;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_avail   = r_rx_avail;
  assign rx_error   = r_rx_error;
  assign rx_overrun = r_rx_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_partner_rx.sv
`default_nettype none
// tb_uart_partner_rx: directed bench for uart_partner_rx at CPB=86.
// Rev 1.0
module tb_uart_partner_rx;

  localparam int CPB = 86;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cyc;

  always #5 clk = ~clk;

  uart_partner_rx #(
    .clk_freq       (100000000),
    .uart_baud_rate (1152000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_avail   (rx_avail),
    .rx_ack     (rx_ack),
    .rx_error   (rx_error),
    .rx_overrun (rx_overrun),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  // Drives ncyc cycles of a frame; optional ack or reset pulse at a given cycle.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit,
                             input int ack_cyc, input int rst_cyc, input int ncyc);
    logic [9:0] bits;
    logic       prev;
    bits     = {stop_bit, d, 1'b0};
    rise_cyc = -1;
    prev     = rx_avail;
    for (int c = 0; c < ncyc; c++) begin
      uart_rxd = bits[c / CPB];
      rx_ack   = (c == ack_cyc);
      rst      = (c == rst_cyc) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (rx_avail && !prev && rise_cyc < 0) rise_cyc = c + 1;
      prev = rx_avail;
    end
    rx_ack   = 1'b0;
    rst      = 1'b1;
    uart_rxd = stop_bit;
  endtask

  initial begin
    int busy_low;
    logic seen_busy;

    // Reset and idle
    rst = 1'b0;
    uart_rxd = 1'b1;
    idle(4);
    check("rst_busy", busy, 0);
    check("rst_avail", rx_avail, 0);
    check("rst_error", rx_error, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_data", rx_data, 8'h00);
    rst = 1'b1;
    idle(1000);
    check("idle_busy", busy, 0);
    check("idle_avail", rx_avail, 0);

    // Single bytes with ack
    drive_frame(8'h55, 1'b1, -1, -1, 10 * CPB);
    check("lat_55", (rise_cyc >= 820 && rise_cyc <= 822), 1);
    check("data_55", rx_data, 8'h55);
    check("avail_55", rx_avail, 1);
    check("err_55", rx_error, 0);
    check("ovr_55", rx_overrun, 0);
    pulse_ack();
    check("ack_avail_55", rx_avail, 0);
    drive_frame(8'hA3, 1'b1, -1, -1, 10 * CPB);
    check("lat_A3", (rise_cyc >= 820 && rise_cyc <= 822), 1);
    check("data_A3", rx_data, 8'hA3);
    check("err_A3", rx_error, 0);
    check("ovr_A3", rx_overrun, 0);
    pulse_ack();
    check("ack_avail_A3", rx_avail, 0);

    // Overrun, then ack
    drive_frame(8'h01, 1'b1, -1, -1, 10 * CPB);
    drive_frame(8'h02, 1'b1, -1, -1, 10 * CPB);
    check("ovr_data", rx_data, 8'h02);
    check("ovr_avail", rx_avail, 1);
    check("ovr_flag", rx_overrun, 1);
    pulse_ack();
    check("ovr_ack_avail", rx_avail, 0);
    check("ovr_ack_flag", rx_overrun, 0);

    // Ack in the load cycle of byte 2
    drive_frame(8'h01, 1'b1, -1, -1, 10 * CPB);
    drive_frame(8'h02, 1'b1, 819, -1, 10 * CPB);
    check("race_avail", rx_avail, 1);
    check("race_data", rx_data, 8'h02);
    check("race_ovr", rx_overrun, 0);
    pulse_ack();
    check("race_ack_avail", rx_avail, 0);

    // Framing error followed by a held-low line
    drive_frame(8'hFF, 1'b0, -1, -1, 10 * CPB);
    busy_low = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_low++;
    end
    check("brk_busy_low_cycles", busy_low, 0);
    check("brk_error", rx_error, 1);
    check("brk_avail", rx_avail, 0);
    check("brk_data", rx_data, 8'h02);
    uart_rxd = 1'b1;
    idle(100);
    check("brk_exit_busy", busy, 0);
    drive_frame(8'h3C, 1'b1, -1, -1, 10 * CPB);
    check("post_brk_data", rx_data, 8'h3C);
    check("post_brk_avail", rx_avail, 1);
    check("post_brk_error", rx_error, 1);
    check("post_brk_ovr", rx_overrun, 0);
    pulse_ack();
    check("post_brk_ack_err", rx_error, 0);
    check("post_brk_ack_avail", rx_avail, 0);

    // Glitch rejection
    seen_busy = 1'b0;
    for (int c = 0; c < 100; c++) begin
      uart_rxd = (c < 20) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (busy) seen_busy = 1'b1;
    end
    check("glitch_seen_busy", seen_busy, 1);
    check("glitch_busy", busy, 0);
    check("glitch_avail", rx_avail, 0);
    check("glitch_err", rx_error, 0);
    check("glitch_ovr", rx_overrun, 0);
    drive_frame(8'h7E, 1'b1, -1, -1, 10 * CPB);
    check("data_7E", rx_data, 8'h7E);
    check("avail_7E", rx_avail, 1);
    pulse_ack();

    // Reset during data bit 4 of 0x99
    drive_frame(8'h99, 1'b1, -1, 5 * CPB + 40, 5 * CPB + 50);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_avail", rx_avail, 0);
    check("midrst_busy", busy, 0);
    idle(200);
    check("midrst_idle_avail", rx_avail, 0);
    drive_frame(8'h42, 1'b1, -1, -1, 10 * CPB);
    check("data_42", rx_data, 8'h42);
    check("avail_42", rx_avail, 1);
    check("err_42", rx_error, 0);
    check("ovr_42", rx_overrun, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
